fme_hpel_row_ctrl: RTL

- Sequencer for the FME horizontal half-pel interpolation path.
- Accepts a streamed block of integer reference pixels row by row and keeps a 6-pixel sliding window.
- Drives a 2-stage pipelined 6-tap filter (1,-5,20,20,-5,1) and emits rounded, clipped half-pel samples with valid/ready backpressure, plus row/column tags and a done pulse for the downstream quarter-pel stage.

---
 rtl/fme_hpel_row_ctrl_pkg.sv | 11 +
 rtl/fme_tap6_pipe.sv | 109 ++++++++++
 rtl/fme_hpel_row_ctrl.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/fme_hpel_row_ctrl_pkg.sv
// Shared constants and state type for the FME half-pel row path (package fme_pkg).
package fme_pkg;
  localparam int HP_SUM_W = 15;
  localparam int HP_SHIFT = 5;
  localparam logic signed [HP_SUM_W-1:0] TAP_C1  = 15'sd1;
  localparam logic signed [HP_SUM_W-1:0] TAP_C5  = 15'sd5;
  localparam logic signed [HP_SUM_W-1:0] TAP_C20 = 15'sd20;
  localparam logic signed [HP_SUM_W-1:0] HP_RND  = 15'sd16;

  typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} hpel_state_t;
endpackage

// File: rtl/fme_tap6_pipe.sv
// Two-stage 6-tap (1,-5,20,20,-5,1) half-pel filter with round/clip.
// Optional macro FME_HPEL_RAW_EN adds the unrounded stage-2 sum output.
module fme_tap6_pipe
  import fme_pkg::*;
#(
  parameter int PIX_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_vld,
  input  logic [PIX_W-1:0] i_p0,
  input  logic [PIX_W-1:0] i_p1,
  input  logic [PIX_W-1:0] i_p2,
  input  logic [PIX_W-1:0] i_p3,
  input  logic [PIX_W-1:0] i_p4,
  input  logic [PIX_W-1:0] i_p5,
  input  logic [5:0]       i_col,
  input  logic [5:0]       i_row,
  input  logic             i_last,
  output logic             o_s1_vld,
  output logic             o_vld,
  output logic [7:0]       o_data,
  output logic [5:0]       o_col,
  output logic [5:0]       o_row,
`ifdef FME_HPEL_RAW_EN
  output logic signed [HP_SUM_W-1:0] o_raw,
`endif
  output logic             o_last
);

  logic [PIX_W:0] r_af, r_be, r_cd;
  logic           r_s1_vld, r_s1_last;
  logic [5:0]     r_s1_col, r_s1_row;

  logic           r_s2_vld, r_s2_last;
  logic [7:0]     r_s2_data;
  logic [5:0]     r_s2_col, r_s2_row;

  logic signed [HP_SUM_W-1:0] w_af, w_be, w_cd, w_sum, w_rnd, w_shf;
  logic [7:0]                 w_clip;

  // Stage 1: symmetric tap pair sums.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_af <= '0; r_be <= '0; r_cd <= '0;
      r_s1_vld <= 1'b0; r_s1_last <= 1'b0;
      r_s1_col <= '0; r_s1_row <= '0;
    end else if (i_en) begin
      r_af      <= {1'b0, i_p0} + {1'b0, i_p5};
      r_be      <= {1'b0, i_p1} + {1'b0, i_p4};
      r_cd      <= {1'b0, i_p2} + {1'b0, i_p3};
      r_s1_vld  <= i_vld;
      r_s1_last <= i_last;
      r_s1_col  <= i_col;
      r_s1_row  <= i_row;
    end
  end

  assign w_af  = signed'({{(HP_SUM_W-PIX_W-1){1'b0}}, r_af});
  assign w_be  = signed'({{(HP_SUM_W-PIX_W-1){1'b0}}, r_be});
  assign w_cd  = signed'({{(HP_SUM_W-PIX_W-1){1'b0}}, r_cd});
  assign w_sum = w_af * TAP_C1 - w_be * TAP_C5 + w_cd * TAP_C20;
  assign w_rnd = w_sum + HP_RND;
  assign w_shf = w_rnd >>> HP_SHIFT;

  // Clip rounded sum into the 8-bit pixel range.
  always_comb begin
    w_clip = w_shf[7:0];
    if (w_sum < 0)
      w_clip = 8'd0;
    else if (w_shf > 15'sd255)
      w_clip = 8'd255;
  end

  // Stage 2: output register, held while downstream stalls.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s2_vld <= 1'b0; r_s2_last <= 1'b0; r_s2_data <= '0;
      r_s2_col <= '0; r_s2_row <= '0;
    end else if (i_en) begin
      r_s2_vld  <= r_s1_vld;
      r_s2_last <= r_s1_last;
      r_s2_data <= w_clip;
      r_s2_col  <= r_s1_col;
      r_s2_row  <= r_s1_row;
    end
  end

`ifdef FME_HPEL_RAW_EN
  logic signed [HP_SUM_W-1:0] r_s2_raw;

  // Raw sum kept aligned with the clipped sample for centre filtering.
  always_ff @(posedge i_clk) begin
    if (i_rst)     r_s2_raw <= '0;
    else if (i_en) r_s2_raw <= w_sum;
  end

  assign o_raw = r_s2_raw;
`endif

  assign o_s1_vld = r_s1_vld;
  assign o_vld    = r_s2_vld;
  assign o_data   = r_s2_data;
  assign o_col    = r_s2_col;
  assign o_row    = r_s2_row;
  assign o_last   = r_s2_last;

endmodule

// File: rtl/fme_hpel_row_ctrl.sv
// FME horizontal half-pel row sequencer: sliding window, counters, FSM.
// Optional macro FME_HPEL_RAW_EN exposes o_hp_raw (unrounded sum).
//
// state | meaning
// IDLE  | waiting for start
// FILL  | loading the first 5 pixels of a row into the window
// RUN   | each accepted pixel launches one filter op
// FLUSH | last pixel taken, draining pipeline, then done
module fme_hpel_row_ctrl
  import fme_pkg::*;
#(
  parameter int BLK_W  = 16,
  parameter int N_ROWS = 16,
  parameter int PIX_W  = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  output logic             o_busy,
  output logic             o_done,
  input  logic             i_pix_valid,
  output logic             o_pix_ready,
  input  logic [PIX_W-1:0] i_pix_in,
  output logic             o_hp_valid,
  input  logic             i_hp_ready,
  output logic [7:0]       o_hp_data,
  output logic [5:0]       o_hp_col,
  output logic [5:0]       o_hp_row,
`ifdef FME_HPEL_RAW_EN
  output logic signed [HP_SUM_W-1:0] o_hp_raw,
`endif
  output logic             o_hp_last
);

  localparam logic [5:0] COL_LAST = 6'(BLK_W - 1);
  localparam logic [5:0] ROW_LAST = 6'(N_ROWS - 1);

  hpel_state_t      r_state, w_state_nxt;
  logic [2:0]       r_fill_cnt;
  logic [5:0]       r_col, r_row;
  logic [PIX_W-1:0] r_win [5];

  logic w_adv, w_acc, w_launch, w_col_end, w_row_end, w_empty, w_s1_vld, w_done;

  assign w_adv       = i_hp_ready | ~o_hp_valid;
  assign o_pix_ready = w_adv & ((r_state == FILL) | (r_state == RUN));
  assign w_acc       = i_pix_valid & o_pix_ready;
  assign w_launch    = w_acc & (r_state == RUN);
  assign w_col_end   = (r_col == COL_LAST);
  assign w_row_end   = (r_row == ROW_LAST);
  assign w_empty     = ~w_s1_vld & ~o_hp_valid;

  // Next-state and done decode.
  always_comb begin
    w_state_nxt = r_state;
    w_done      = 1'b0;
    case (r_state)
      IDLE:  if (i_start) w_state_nxt = FILL;
      FILL:  if (w_acc && r_fill_cnt == 3'd4) w_state_nxt = RUN;
      RUN:   if (w_acc && w_col_end) w_state_nxt = w_row_end ? FLUSH : FILL;
      FLUSH: if (w_empty) begin
               w_done      = 1'b1;
               w_state_nxt = IDLE;
             end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register and row/column/fill counters.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_fill_cnt <= '0;
      r_col      <= '0;
      r_row      <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        IDLE: if (i_start) begin
          r_row      <= '0;
          r_col      <= '0;
          r_fill_cnt <= '0;
        end
        FILL: if (w_acc) begin
          r_fill_cnt <= (r_fill_cnt == 3'd4) ? 3'd0 : r_fill_cnt + 3'd1;
          r_col      <= '0;
        end
        RUN: if (w_acc) begin
          if (w_col_end) begin
            r_col      <= '0;
            r_fill_cnt <= '0;
            if (!w_row_end) r_row <= r_row + 6'd1;
          end else begin
            r_col <= r_col + 6'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Five-pixel history; the incoming pixel acts as the newest tap.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < 5; k++) r_win[k] <= '0;
    end else if (w_acc) begin
      for (int k = 0; k < 4; k++) r_win[k] <= r_win[k+1];
      r_win[4] <= i_pix_in;
    end
  end

  fme_tap6_pipe #(.PIX_W(PIX_W)) u_pipe (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_en     (w_adv),
    .i_vld    (w_launch),
    .i_p0     (r_win[0]),
    .i_p1     (r_win[1]),
    .i_p2     (r_win[2]),
    .i_p3     (r_win[3]),
    .i_p4     (r_win[4]),
    .i_p5     (i_pix_in),
    .i_col    (r_col),
    .i_row    (r_row),
    .i_last   (w_col_end & w_row_end),
    .o_s1_vld (w_s1_vld),
    .o_vld    (o_hp_valid),
    .o_data   (o_hp_data),
    .o_col    (o_hp_col),
    .o_row    (o_hp_row),
`ifdef FME_HPEL_RAW_EN
    .o_raw    (o_hp_raw),
`endif
    .o_last   (o_hp_last)
  );

  assign o_busy = (r_state != IDLE);
  assign o_done = w_done;

endmodule
